// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract unit: DIGIT_WIDTH bits per cycle with a registered
// carry/borrow between digits, plus signed overflow and zero flags.

module digit_serial_addsub_param_check #(
    parameter int WIDTH       = 32,
    parameter int DIGIT_WIDTH = 8
) ();
    if (DIGIT_WIDTH < 1 || DIGIT_WIDTH > WIDTH || (WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_params
        $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT_WIDTH with 1 <= DIGIT_WIDTH <= WIDTH");
    end
endmodule

// state | meaning
// IDLE  | waiting for an operand request, in_ready=1
// CALC  | one digit per cycle, carry held in carry_q
// DONE  | result valid, held until out_ready; may accept the next request
module digit_serial_addsub #(
    parameter int WIDTH       = 32,
    parameter int DIGIT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NUM_DIGITS = WIDTH / DIGIT_WIDTH;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    digit_serial_addsub_param_check #(
        .WIDTH      (WIDTH),
        .DIGIT_WIDTH(DIGIT_WIDTH)
    ) u_param_check ();

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-1:0]       result_d;
    logic                   op_sub_q;
    logic                   carry_q;
    logic [CNT_W-1:0]       digit_q;
    logic                   accept;
    logic                   last_digit;
    logic [DIGIT_WIDTH-1:0] a_dig;
    logic [DIGIT_WIDTH-1:0] b_dig;
    logic [DIGIT_WIDTH:0]   dig_sum;

    assign last_digit = (digit_q == LAST_DIGIT);
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // a waiting request is taken in the same cycle the result leaves
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = in_valid ? CALC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // subtraction is A + ~B + ~borrow_in, so B is inverted per digit
    always_comb begin
        a_dig    = a_q[int'(digit_q) * DIGIT_WIDTH +: DIGIT_WIDTH];
        b_dig    = b_q[int'(digit_q) * DIGIT_WIDTH +: DIGIT_WIDTH] ^ {DIGIT_WIDTH{op_sub_q}};
        dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_WIDTH{1'b0}}, carry_q};
        result_d = result;
        result_d[int'(digit_q) * DIGIT_WIDTH +: DIGIT_WIDTH] = dig_sum[DIGIT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_sub_q  <= 1'b0;
            carry_q   <= 1'b0;
            digit_q   <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= input_a;
                b_q      <= input_b;
                op_sub_q <= op_sub;
                carry_q  <= carry_in ^ op_sub;
                digit_q  <= '0;
            end else if (state_q == CALC) begin
                result  <= result_d;
                carry_q <= dig_sum[DIGIT_WIDTH];
                digit_q <= last_digit ? '0 : digit_q + CNT_W'(1);
                if (last_digit) begin
                    carry_out <= dig_sum[DIGIT_WIDTH] ^ op_sub_q;
                    overflow  <= (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ op_sub_q)) &&
                                 (result_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero      <= (result_d == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub over four width/digit configurations.

module tb_digit_serial_addsub;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic [31:0] stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cyc = 32'd0;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [63:0] in_a      [4];
    logic [63:0] in_b      [4];
    logic        cin       [4];
    logic        sub       [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [63:0] res       [4];
    logic        cout      [4];
    logic        ovf       [4];
    logic        zro       [4];

    exp_t        sb        [4][$];
    logic        prev_v    [4];
    logic        prev_hs   [4];
    logic [63:0] prev_res  [4];
    logic [2:0]  prev_fl   [4];

    logic [31:0] r0;
    logic [7:0]  r1;
    logic [15:0] r2;
    logic [63:0] r3;
    assign res[0] = 64'(r0);
    assign res[1] = 64'(r1);
    assign res[2] = 64'(r2);
    assign res[3] = r3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    digit_serial_addsub #(.WIDTH(32), .DIGIT_WIDTH(8)) u_dut_32_8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .input_a(in_a[0][31:0]), .input_b(in_b[0][31:0]), .carry_in(cin[0]), .op_sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(r0),
        .carry_out(cout[0]), .overflow(ovf[0]), .zero(zro[0]));

    digit_serial_addsub #(.WIDTH(8), .DIGIT_WIDTH(8)) u_dut_8_8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .input_a(in_a[1][7:0]), .input_b(in_b[1][7:0]), .carry_in(cin[1]), .op_sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(r1),
        .carry_out(cout[1]), .overflow(ovf[1]), .zero(zro[1]));

    digit_serial_addsub #(.WIDTH(16), .DIGIT_WIDTH(1)) u_dut_16_1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .input_a(in_a[2][15:0]), .input_b(in_b[2][15:0]), .carry_in(cin[2]), .op_sub(sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(r2),
        .carry_out(cout[2]), .overflow(ovf[2]), .zero(zro[2]));

    digit_serial_addsub #(.WIDTH(64), .DIGIT_WIDTH(16)) u_dut_64_16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .input_a(in_a[3]), .input_b(in_b[3]), .carry_in(cin[3]), .op_sub(sub[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .result(r3),
        .carry_out(cout[3]), .overflow(ovf[3]), .zero(zro[3]));

    function automatic int wd(input int i);
        case (i)
            0:       return 32;
            1:       return 8;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int ndig(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic logic [63:0] msk(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // full-width reference: plain integer add/sub with the borrow/carry taken from bit w
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input logic c, input int w);
        logic [64:0] t;
        logic [63:0] r;
        exp_t        e;
        if (s) t = {1'b0, a} - {1'b0, b} - 65'(c);
        else   t = {1'b0, a} + {1'b0, b} + 65'(c);
        r = t[63:0] & msk(w);
        e.r = r;
        e.c = t[w];
        if (s) e.v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
        else   e.v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
        e.z = (r == 64'd0);
        e.stamp = 32'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (rst) begin
            prev_v[i]  = 1'b0;
            prev_hs[i] = 1'b0;
        end else begin
            if (out_valid[i]) begin
                if (!prev_v[i] || prev_hs[i]) begin
                    chk($sformatf("pending_%0d", i), 64'(sb[i].size() != 0), 64'd1);
                    if (sb[i].size() != 0)
                        chk($sformatf("latency_%0d", i), 64'(cyc - sb[i][0].stamp), 64'(ndig(i)));
                end else begin
                    chk($sformatf("hold_result_%0d", i), res[i], prev_res[i]);
                    chk($sformatf("hold_flags_%0d", i), 64'({cout[i], ovf[i], zro[i]}), 64'(prev_fl[i]));
                end
                if (!out_ready[i]) begin
                    chk($sformatf("bp_in_ready_%0d", i), 64'(in_ready[i]), 64'd0);
                end else if (sb[i].size() != 0) begin
                    e = sb[i].pop_front();
                    chk($sformatf("result_%0d", i), res[i], e.r);
                    chk($sformatf("carry_out_%0d", i), 64'(cout[i]), 64'(e.c));
                    chk($sformatf("overflow_%0d", i), 64'(ovf[i]), 64'(e.v));
                    chk($sformatf("zero_%0d", i), 64'(zro[i]), 64'(e.z));
                end
                prev_res[i] = res[i];
                prev_fl[i]  = {cout[i], ovf[i], zro[i]};
            end
            prev_v[i]  = out_valid[i];
            prev_hs[i] = out_valid[i] && out_ready[i];
            if (in_valid[i] && in_ready[i]) begin
                e = model(in_a[i], in_b[i], sub[i], cin[i], wd(i));
                e.stamp = cyc + 32'd1;
                sb[i].push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) mon(i);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one request to every DUT in mask; return once all of them accepted it
    task automatic req(input logic [3:0] mask, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic c);
        logic [3:0] pend;
        logic [3:0] acc;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                in_a[i] = a & msk(wd(i));
                in_b[i] = b & msk(wd(i));
                sub[i]  = s;
                cin[i]  = c;
                in_valid[i] = 1'b1;
            end
        end
        pend = mask;
        for (int k = 0; k < 60 && pend != 4'd0; k++) begin
            #1;
            acc = 4'd0;
            for (int i = 0; i < 4; i++) if (pend[i] && in_ready[i]) acc[i] = 1'b1;
            step();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    in_valid[i] = 1'b0;
                    in_a[i] = {$urandom, $urandom} & msk(wd(i));
                    in_b[i] = {$urandom, $urandom} & msk(wd(i));
                    sub[i]  = ~sub[i];
                    cin[i]  = ~cin[i];
                end
            end
            pend = pend & ~acc;
        end
        if (pend != 4'd0) chk("accept_timeout", 64'(pend), 64'd0);
    endtask

    function automatic int pending_total();
        int n = 0;
        for (int i = 0; i < 4; i++) n += sb[i].size();
        return n;
    endfunction

    task automatic drain();
        for (int k = 0; k < 200 && pending_total() != 0; k++) step();
        chk("drain_timeout", 64'(pending_total()), 64'd0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
            cin[i] = 1'b0; sub[i] = 1'b0; out_ready[i] = 1'b1;
            prev_v[i] = 1'b0; prev_hs[i] = 1'b0; prev_res[i] = '0; prev_fl[i] = '0;
        end
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_in_ready_%0d", i), 64'(in_ready[i]), 64'd1);
            chk($sformatf("reset_out_valid_%0d", i), 64'(out_valid[i]), 64'd0);
        end
        rst = 1'b0;
        step();

        // directed 32/8 cases, issued back to back
        req(4'b0001, 64'h0000_00FF, 64'h0000_0001, 1'b0, 1'b0);
        req(4'b0001, 64'h0000_0000, 64'h0000_0001, 1'b1, 1'b0);
        req(4'b0001, 64'h0000_0005, 64'h0000_0005, 1'b1, 1'b0);
        req(4'b0001, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1'b0);
        req(4'b0001, 64'h8000_0000, 64'h0000_0001, 1'b1, 1'b0);
        drain();

        // back-pressure, then chained accept on the releasing edge
        out_ready[0] = 1'b0;
        req(4'b0001, 64'h1234_5678, 64'h0FED_CBA9, 1'b0, 1'b1);
        in_a[0] = 64'h0000_0010; in_b[0] = 64'h0000_0020; sub[0] = 1'b1; cin[0] = 1'b0;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 20 && !out_valid[0]; k++) step();
        chk("bp_out_valid_seen", 64'(out_valid[0]), 64'd1);
        repeat (10) step();
        out_ready[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        drain();

        // reset while digit 2 is in flight
        req(4'b0001, 64'hDEAD_BEEF, 64'h0101_0101, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) sb[i].delete();
        step();
        chk("midreset_in_ready", 64'(in_ready[0]), 64'd1);
        chk("midreset_out_valid", 64'(out_valid[0]), 64'd0);
        rst = 1'b0;
        repeat (8) step();
        req(4'b0001, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 1'b0);
        drain();

        // boundary cases across all widths
        req(4'b0010, 64'h0000_0000_0000_00FF, 64'h0, 1'b0, 1'b1);
        req(4'b1111, 64'h0, {64{1'b1}}, 1'b1, 1'b1);
        req(4'b1111, {64{1'b1}}, {64{1'b1}}, 1'b0, 1'b1);
        drain();

        for (int n = 0; n < 16; n++) begin
            req(4'b1111, {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
